// File: rtl/mem_resp_pkg.sv
// Shared encodings for the mem_resp responder: bus opcodes, FSM states and
// the word-wrap helper used for the second beat of an instruction fetch.
package mem_resp_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    SEL_NOP   = 2'b00,
    SEL_RD    = 2'b01,
    SEL_WR    = 2'b10,
    SEL_FETCH = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Next word address with wrap from depth-1 back to 0.
  function automatic logic [15:0] next_word(input logic [15:0] a, input int depth);
    if (32'(a) == 32'(depth - 1)) return 16'd0;
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word array: synchronous write, combinational read of the
// registered address supplied by the controller. Contents are never reset.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder for the 16-bit request/ready bus. Optional write
// protection of the low PROT_LIMIT words is built when MEM_PROT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for cs with a non-nop sel
//   WAIT  | wait states counting down before a beat
//   RESP  | one-cycle ready pulse for the beat just issued
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_LIMIT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [1:0]  sel,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        bus_oe,
  output logic        ready,
  output logic        last,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_FIRST = CW'(WAIT_CYCLES);
  // Second fetch beat: the RESP cycle of beat 0 already counts as one wait state.
  localparam logic [CW-1:0] CNT_NEXT  = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_e            state_q;
  sel_e              op_q;
  logic [15:0]       ptr_q;
  logic [15:0]       wdata_q;
  logic [CW-1:0]     cnt_q;
  logic              beat_q;
  logic [15:0]       rdata_q;
  logic              oe_q, ready_q, last_q, err_q, busy_q;

  logic [15:0]       ptr_d;
  logic              in_range, prot_hit, fault, beat_due, last_beat, has_data, ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign ptr_d    = next_word(ptr_q, DEPTH);
  assign in_range = 32'(ptr_q) < DEPTH;

`ifdef MEM_PROT_EN
  assign prot_hit = (op_q == SEL_WR) && (32'(ptr_q) < PROT_LIMIT);
`else
  // Protection not built; the term is constant false for any sane limit.
  assign prot_hit = (PROT_LIMIT < 0);
`endif

  assign fault     = !in_range || prot_hit;
  assign beat_due  = (state_q == WAIT && cnt_q == '0) ||
                     (state_q == RESP && !last_q && WAIT_CYCLES == 0);
  assign last_beat = fault || (op_q != SEL_FETCH) || beat_q;
  assign has_data  = !fault && (op_q != SEL_WR);
  assign ram_we    = reset && beat_due && (op_q == SEL_WR) && !fault;

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ptr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= SEL_NOP;
      ptr_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdata_q <= '0;

      unique case (state_q)
        IDLE: begin
          if (cs && sel != SEL_NOP) begin
            op_q    <= sel_e'(sel);
            ptr_q   <= addr;
            wdata_q <= wdata;
            cnt_q   <= CNT_FIRST;
            beat_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        RESP: begin
          if (last_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (WAIT_CYCLES != 0) begin
            cnt_q   <= CNT_NEXT;
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (beat_due) begin
        ready_q <= 1'b1;
        last_q  <= last_beat;
        err_q   <= fault;
        oe_q    <= has_data;
        rdata_q <= has_data ? ram_rdata : '0;
        state_q <= RESP;
        if (!last_beat) begin
          ptr_q  <= ptr_d;
          beat_q <= 1'b1;
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign bus_oe = oe_q;
  assign ready  = ready_q;
  assign last   = last_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: one instance with one wait state, one with none.
module tb_mem_resp;
  import mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cs_a, cs_b;
  logic [1:0]  sel;
  logic [15:0] addr, wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        oe_a, ready_a, last_a, err_a, busy_a;
  logic        oe_b, ready_b, last_b, err_b, busy_b;
  logic [20:0] obs_a, obs_b;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mem_resp #(.DEPTH(1024), .WAIT_CYCLES(1), .PROT_LIMIT(64)) u_a (
    .clk(clk), .reset(reset), .cs(cs_a), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .bus_oe(oe_a), .ready(ready_a), .last(last_a), .err(err_a), .busy(busy_a));

  mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0), .PROT_LIMIT(64)) u_b (
    .clk(clk), .reset(reset), .cs(cs_b), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .bus_oe(oe_b), .ready(ready_b), .last(last_b), .err(err_b), .busy(busy_b));

  // {ready, last, err, bus_oe, busy, rdata}
  assign obs_a = {ready_a, last_a, err_a, oe_a, busy_a, rdata_a};
  assign obs_b = {ready_b, last_b, err_b, oe_b, busy_b, rdata_b};

  localparam logic [20:0] IDLE_OBS = 21'h0;
  localparam logic [20:0] BUSY_OBS = 21'h10000;

  function automatic logic [20:0] cur(input bit which);
    return which ? obs_b : obs_a;
  endfunction

  function automatic logic [20:0] beat_v(input logic l, input logic e, input logic oe,
                                         input logic [15:0] d);
    return {1'b1, l, e, oe, 1'b1, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] got, input logic [31:0] bad);
    vectors++;
    assert (got !== bad) else begin
      miscompares++;
      $error("FAIL %s: observed %h must differ from %h", tag, got, bad);
    end
  endtask

  task automatic issue(input bit which, input logic [1:0] s, input logic [15:0] a,
                       input logic [15:0] d);
    sel = s; addr = a; wdata = d;
    if (which) cs_b = 1'b1; else cs_a = 1'b1;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; sel = 2'b00; addr = '0; wdata = '0;
  endtask

  task automatic wait_beat(input bit which, output int cyc, output logic [20:0] seen);
    logic [20:0] o;
    cyc = 0; seen = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      o = cur(which);
      if (o[20]) begin
        cyc = i; seen = o;
        break;
      end
    end
  endtask

  task automatic expect_beat(input string tag, input bit which, input int lat,
                             input logic [20:0] exp);
    int cyc;
    logic [20:0] seen;
    wait_beat(which, cyc, seen);
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check(tag, {11'b0, seen}, {11'b0, exp});
  endtask

  task automatic expect_idle(input string tag, input bit which);
    @(posedge clk); #1;
    check(tag, {11'b0, cur(which)}, {11'b0, IDLE_OBS});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [20:0] seen;

    reset = 1'b0; cs_a = 1'b0; cs_b = 1'b0; sel = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {11'b0, obs_a}, {11'b0, IDLE_OBS});
    check("reset_b", {11'b0, obs_b}, {11'b0, IDLE_OBS});
    reset = 1'b1;

    // One wait state: ready two edges after acceptance.
    issue(0, SEL_WR, 16'd5, 16'hBEEF);
    expect_beat("wr5", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr5_end", 0);
    issue(0, SEL_RD, 16'd5, 16'h0);
    check("rd5_busy", {11'b0, obs_a}, {11'b0, BUSY_OBS});
    expect_beat("rd5", 0, 2, beat_v(1, 0, 1, 16'hBEEF));
    expect_idle("rd5_end", 0);

    issue(0, SEL_WR, 16'd300, 16'h1234);
    expect_beat("wr300", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr300_end", 0);
    issue(0, SEL_RD, 16'd300, 16'h0);
    expect_beat("rd300", 0, 2, beat_v(1, 0, 1, 16'h1234));
    expect_idle("rd300_end", 0);

    issue(0, SEL_NOP, 16'd5, 16'h0);
    check("nop_ignored", {11'b0, obs_a}, {11'b0, IDLE_OBS});
    expect_idle("nop_quiet1", 0);
    expect_idle("nop_quiet2", 0);

    // Fetch across the top of the array wraps to word 0.
    issue(0, SEL_WR, 16'd1023, 16'h7777);
    expect_beat("wr1023", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr1023_end", 0);
    issue(0, SEL_WR, 16'd0, 16'h0102);
    expect_beat("wr0", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr0_end", 0);
    issue(0, SEL_FETCH, 16'd1023, 16'h0);
    expect_beat("fwrap_b0", 0, 2, beat_v(0, 0, 1, 16'h7777));
    expect_beat("fwrap_b1", 0, 2, beat_v(1, 0, 1, 16'h0102));
    expect_idle("fwrap_end", 0);

    issue(0, SEL_RD, 16'hFFFF, 16'h0);
    expect_beat("rd_oor", 0, 2, beat_v(1, 1, 0, 16'h0000));
    expect_idle("rd_oor_end", 0);
    issue(0, SEL_FETCH, 16'd1024, 16'h0);
    expect_beat("fetch_oor", 0, 2, beat_v(1, 1, 0, 16'h0000));
    expect_idle("fetch_oor_end", 0);
    issue(0, SEL_WR, 16'd1024, 16'hDEAD);
    expect_beat("wr_oor", 0, 2, beat_v(1, 1, 0, 16'h0000));
    expect_idle("wr_oor_end", 0);

`ifdef MEM_PROT_EN
    issue(0, SEL_WR, 16'd3, 16'hFFFF);
    expect_beat("wr3_prot", 0, 2, beat_v(1, 1, 0, 16'h0000));
    expect_idle("wr3_prot_end", 0);
    issue(0, SEL_RD, 16'd3, 16'h0);
    wait_beat(0, cyc, seen);
    check("rd3_prot_lat", 32'(cyc), 32'd2);
    check("rd3_prot_flags", {27'b0, seen[20:16]}, {27'b0, 5'b11011});
    check_ne("rd3_prot_data", {16'b0, seen[15:0]}, 32'h0000FFFF);
    expect_idle("rd3_prot_end", 0);
`else
    issue(0, SEL_WR, 16'd3, 16'hFFFF);
    expect_beat("wr3", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr3_end", 0);
    issue(0, SEL_RD, 16'd3, 16'h0);
    expect_beat("rd3", 0, 2, beat_v(1, 0, 1, 16'hFFFF));
    expect_idle("rd3_end", 0);
`endif
    issue(0, SEL_WR, 16'd64, 16'h4064);
    expect_beat("wr64", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr64_end", 0);
    issue(0, SEL_RD, 16'd64, 16'h0);
    expect_beat("rd64", 0, 2, beat_v(1, 0, 1, 16'h4064));
    expect_idle("rd64_end", 0);

    // Zero wait states: back-to-back fetch beats.
    issue(1, SEL_WR, 16'd10, 16'h0001);
    expect_beat("b_wr10", 1, 1, beat_v(1, 0, 0, 16'h0000));
    expect_idle("b_wr10_end", 1);
    issue(1, SEL_WR, 16'd11, 16'hA5A5);
    expect_beat("b_wr11", 1, 1, beat_v(1, 0, 0, 16'h0000));
    expect_idle("b_wr11_end", 1);
    issue(1, SEL_FETCH, 16'd10, 16'h0);
    expect_beat("b_fetch_b0", 1, 1, beat_v(0, 0, 1, 16'h0001));
    expect_beat("b_fetch_b1", 1, 1, beat_v(1, 0, 1, 16'hA5A5));
    expect_idle("b_fetch_end", 1);

    // Reset during the second beat's wait state abandons the fetch.
    issue(0, SEL_WR, 16'd11, 16'hA5A5);
    expect_beat("wr11", 0, 2, beat_v(1, 0, 0, 16'h0000));
    expect_idle("wr11_end", 0);
    issue(0, SEL_FETCH, 16'd1023, 16'h0);
    expect_beat("rfetch_b0", 0, 2, beat_v(0, 0, 1, 16'h7777));
    @(posedge clk); #1;
    check("rfetch_gap", {11'b0, obs_a}, {11'b0, BUSY_OBS});
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid", {11'b0, obs_a}, {11'b0, IDLE_OBS});
    reset = 1'b1;
    expect_idle("rst_quiet1", 0);
    expect_idle("rst_quiet2", 0);
    expect_idle("rst_quiet3", 0);
    issue(0, SEL_RD, 16'd11, 16'h0);
    expect_beat("rd11_after_rst", 0, 2, beat_v(1, 0, 1, 16'hA5A5));
    expect_idle("rd11_end", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
